// File: rtl/tap_controller_if.sv
// JTAG TAP controller port bundle: the TMS input plus the decoded state and the IR/DR strobes.
// The controller sits on the slave side; the test logic or the IR/DR cells observe through master.
interface tap_controller_if;
  logic       TMS;
  logic [3:0] State;
  logic       Reset;
  logic       ShiftIR;
  logic       ClockIR;
  logic       UpdateIR;
  logic       ShiftDR;
  logic       ClockDR;
  logic       UpdateDR;
  logic       Select;
  logic       Enable;

  modport master (
    output TMS,
    input  State, Reset, ShiftIR, ClockIR, UpdateIR, ShiftDR, ClockDR, UpdateDR, Select, Enable
  );

  modport slave (
    input  TMS,
    output State, Reset, ShiftIR, ClockIR, UpdateIR, ShiftDR, ClockDR, UpdateDR, Select, Enable
  );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine: advances one state per rising TCK under TMS and Moore-decodes
// the state into the IR/DR cell strobes and the TDO mux select/enable.
module tap_controller (
  input logic              TCK,
  input logic              TRSTn,
  tap_controller_if.slave  bus
);

  // Encoding matches the standard's suggested values so State can be read off a logic analyser.
  typedef enum logic [3:0] {
    StExit2Dr = 4'h0,
    StExit1Dr = 4'h1,
    StShiftDr = 4'h2,
    StPauseDr = 4'h3,
    StSelIr   = 4'h4,
    StUpdDr   = 4'h5,
    StCapDr   = 4'h6,
    StSelDr   = 4'h7,
    StExit2Ir = 4'h8,
    StExit1Ir = 4'h9,
    StShiftIr = 4'hA,
    StPauseIr = 4'hB,
    StRti     = 4'hC,
    StUpdIr   = 4'hD,
    StCapIr   = 4'hE,
    StTlr     = 4'hF
  } tap_state_e;

  tap_state_e state_q, state_d;

  // State register; TRSTn wins over TMS.
  always_ff @(posedge TCK) begin
    if (!TRSTn) begin
      state_q <= StTlr;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = StTlr;
    case (state_q)
      StTlr:     state_d = bus.TMS ? StTlr     : StRti;
      StRti:     state_d = bus.TMS ? StSelDr   : StRti;
      StSelDr:   state_d = bus.TMS ? StSelIr   : StCapDr;
      StCapDr:   state_d = bus.TMS ? StExit1Dr : StShiftDr;
      StShiftDr: state_d = bus.TMS ? StExit1Dr : StShiftDr;
      StExit1Dr: state_d = bus.TMS ? StUpdDr   : StPauseDr;
      StPauseDr: state_d = bus.TMS ? StExit2Dr : StPauseDr;
      StExit2Dr: state_d = bus.TMS ? StUpdDr   : StShiftDr;
      StUpdDr:   state_d = bus.TMS ? StSelDr   : StRti;
      StSelIr:   state_d = bus.TMS ? StTlr     : StCapIr;
      StCapIr:   state_d = bus.TMS ? StExit1Ir : StShiftIr;
      StShiftIr: state_d = bus.TMS ? StExit1Ir : StShiftIr;
      StExit1Ir: state_d = bus.TMS ? StUpdIr   : StPauseIr;
      StPauseIr: state_d = bus.TMS ? StExit2Ir : StPauseIr;
      StExit2Ir: state_d = bus.TMS ? StUpdIr   : StShiftIr;
      StUpdIr:   state_d = bus.TMS ? StSelDr   : StRti;
      default:   state_d = StTlr;
    endcase
  end

  // Output decode: a pure function of state_q, so no strobe can glitch with TMS.
  always_comb begin
    bus.State    = state_q;
    bus.Reset    = 1'b0;
    bus.ShiftIR  = 1'b0;
    bus.ClockIR  = 1'b0;
    bus.UpdateIR = 1'b0;
    bus.ShiftDR  = 1'b0;
    bus.ClockDR  = 1'b0;
    bus.UpdateDR = 1'b0;
    bus.Select   = 1'b0;
    bus.Enable   = 1'b0;
    case (state_q)
      StTlr:     bus.Reset = 1'b1;
      StCapDr:   bus.ClockDR = 1'b1;
      StShiftDr: begin
        bus.ShiftDR = 1'b1;
        bus.ClockDR = 1'b1;
        bus.Enable  = 1'b1;
      end
      StUpdDr:   bus.UpdateDR = 1'b1;
      StSelIr, StExit1Ir, StPauseIr, StExit2Ir: bus.Select = 1'b1;
      StCapIr:   begin
        bus.ClockIR = 1'b1;
        bus.Select  = 1'b1;
      end
      StShiftIr: begin
        bus.ShiftIR = 1'b1;
        bus.ClockIR = 1'b1;
        bus.Select  = 1'b1;
        bus.Enable  = 1'b1;
      end
      StUpdIr:   begin
        bus.UpdateIR = 1'b1;
        bus.Select   = 1'b1;
      end
      default:   ;
    endcase
  end

endmodule
